accum_frame_packer: RTL and testbench

//  Downstream of the data accumulator, on its slow read clock. Pops 16-bit summed

---
 rtl/accum_frame_packer.sv | 184 ++++++++++++++++++
 tb/tb_accum_frame_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_frame_packer.sv
// Frame packer: pops 16-bit words from a FWFT FIFO and sends them to a UART as
// byte frames (header, sequence number, big-endian words, 8-bit additive checksum).
module accum_frame_packer #(
    parameter int          WORDS_PER_FRAME  = 128,
    parameter logic [7:0]  HDR0             = 8'hA5,
    parameter logic [7:0]  HDR1             = 8'h5A,
    parameter int          UNDERRUN_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] dataIn,
    input  logic        dataEmpty,
    output logic        dataRead,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        frameDone,
    output logic        frameAbort,
    output logic [7:0]  seqNum
);

    localparam int WCW = (WORDS_PER_FRAME  > 1) ? $clog2(WORDS_PER_FRAME)  : 1;
    localparam int TCW = (UNDERRUN_TIMEOUT > 1) ? $clog2(UNDERRUN_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_SEQ,
        S_LOAD,
        S_SEND_HI,
        S_SEND_LO,
        S_CSUM
    } state_t;

    state_t           state_q,      state_d;
    logic [7:0]       tx_data_q,    tx_data_d;
    logic             tx_valid_q,   tx_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_abort_q, frame_abort_d;
    logic [7:0]       seq_q,        seq_d;
    logic [7:0]       csum_q,       csum_d;
    logic [WCW-1:0]   wcnt_q,       wcnt_d;
    logic [TCW-1:0]   tcnt_q,       tcnt_d;
    logic [15:0]      word_q,       word_d;
    logic             accept;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign accept = tx_valid_q & txReady;

    // The pop strobe must coincide with the word being latched, so it is decoded
    // from the current state rather than registered; held low while in reset.
    assign dataRead   = rst & (state_q == S_LOAD) & ~dataEmpty;
    assign txData     = tx_data_q;
    assign txValid    = tx_valid_q;
    assign frameDone  = frame_done_q;
    assign frameAbort = frame_abort_q;
    assign seqNum     = seq_q;

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        seq_d         = seq_q;
        csum_d        = csum_q;
        wcnt_d        = wcnt_q;
        tcnt_d        = tcnt_q;
        word_d        = word_q;

        case (state_q)
            S_IDLE: begin
                if (enable && !dataEmpty) begin
                    state_d    = S_HDR0;
                    csum_d     = 8'h00;
                    tx_data_d  = HDR0;
                    tx_valid_d = 1'b1;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    state_d   = S_HDR1;
                    tx_data_d = HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    state_d   = S_SEQ;
                    tx_data_d = seq_q;
                end
            end
            S_SEQ: begin
                if (accept) begin
                    csum_d     = csum_add(csum_q, tx_data_q);
                    state_d    = S_LOAD;
                    tx_valid_d = 1'b0;
                    wcnt_d     = '0;
                    tcnt_d     = '0;
                end
            end
            S_LOAD: begin
                if (!dataEmpty) begin
                    word_d     = dataIn;
                    state_d    = S_SEND_HI;
                    tx_data_d  = dataIn[15:8];
                    tx_valid_d = 1'b1;
                    tcnt_d     = '0;
                end else if (tcnt_q == TCW'(UNDERRUN_TIMEOUT - 1)) begin
                    // Underrun: drop the partial frame, keep the sequence number
                    frame_abort_d = 1'b1;
                    state_d       = S_IDLE;
                    tcnt_d        = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_SEND_HI: begin
                if (accept) begin
                    csum_d    = csum_add(csum_q, tx_data_q);
                    state_d   = S_SEND_LO;
                    tx_data_d = word_q[7:0];
                end
            end
            S_SEND_LO: begin
                if (accept) begin
                    csum_d = csum_add(csum_q, tx_data_q);
                    if (wcnt_q == WCW'(WORDS_PER_FRAME - 1)) begin
                        // Checksum byte includes the low byte being accepted now
                        state_d   = S_CSUM;
                        tx_data_d = csum_add(csum_q, tx_data_q);
                        wcnt_d    = '0;
                    end else begin
                        wcnt_d     = wcnt_q + 1'b1;
                        state_d    = S_LOAD;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    frame_done_d = 1'b1;
                    seq_d        = seq_q + 8'd1;
                    state_d      = S_IDLE;
                    tx_valid_d   = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            seq_q         <= 8'h00;
            csum_q        <= 8'h00;
            wcnt_q        <= '0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
            seq_q         <= seq_d;
            csum_q        <= csum_d;
            wcnt_q        <= wcnt_d;
            tcnt_q        <= tcnt_d;
        end
        word_q <= word_d;
    end

endmodule

// File: tb/tb_accum_frame_packer.sv
// Directed bench for accum_frame_packer: a 4-word/16-cycle-timeout instance for
// framing, backpressure, underrun, reset and enable; a 1-word instance for seq wrap.
module tb_accum_frame_packer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: 4 words per frame, 16-cycle underrun timeout
    logic        a_en = 1'b0, a_rdy = 1'b1;
    logic [15:0] a_din;
    logic        a_empty, a_rd, a_txv, a_done, a_abort;
    logic [7:0]  a_txd, a_seq;
    logic [15:0] amem [256];
    logic [7:0]  arp = 8'd0, awp = 8'd0;
    assign a_din   = amem[arp];
    assign a_empty = (arp == awp);

    accum_frame_packer #(.WORDS_PER_FRAME(4), .UNDERRUN_TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .enable(a_en), .dataIn(a_din), .dataEmpty(a_empty),
        .dataRead(a_rd), .txData(a_txd), .txValid(a_txv), .txReady(a_rdy),
        .frameDone(a_done), .frameAbort(a_abort), .seqNum(a_seq));

    // Instance B: 1 word per frame, FIFO always holds 0000
    logic        b_en = 1'b0, b_rdy = 1'b1;
    logic [15:0] b_din = 16'h0000;
    logic        b_empty = 1'b0;
    logic        b_rd, b_txv, b_done, b_abort;
    logic [7:0]  b_txd, b_seq;

    accum_frame_packer #(.WORDS_PER_FRAME(1)) dut_b (
        .clk(clk), .rst(rst), .enable(b_en), .dataIn(b_din), .dataEmpty(b_empty),
        .dataRead(b_rd), .txData(b_txd), .txValid(b_txv), .txReady(b_rdy),
        .frameDone(b_done), .frameAbort(b_abort), .seqNum(b_seq));

    // Monitors sample on the falling edge, midway between input updates and the active edge
    logic [7:0] acap [512];
    logic [7:0] bcap [2048];
    int acapN = 0, bcapN = 0, cyc = 0, lastAcc = 0, abortCyc = 0;
    int rdCnt = 0, popEmpty = 0, doneCnt = 0, abortCnt = 0, txvCnt = 0, stabErr = 0;
    logic stall = 1'b0, popA = 1'b0;
    logic [7:0] stallData = 8'h00;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (a_txv && a_rdy) begin
            if (acapN < 512) acap[acapN] = a_txd;
            acapN = acapN + 1;
            lastAcc = cyc;
        end
        if (a_rd) rdCnt = rdCnt + 1;
        if (a_rd && a_empty) popEmpty = popEmpty + 1;
        if (a_done) doneCnt = doneCnt + 1;
        if (a_abort) begin
            abortCnt = abortCnt + 1;
            abortCyc = cyc;
        end
        if (a_txv) txvCnt = txvCnt + 1;
        if (stall && (!a_txv || a_txd !== stallData)) stabErr = stabErr + 1;
        stall     = a_txv && !a_rdy;
        stallData = a_txd;
        popA      = a_rd;
        if (b_txv && b_rdy) begin
            if (bcapN < 2048) bcap[bcapN] = b_txd;
            bcapN = bcapN + 1;
        end
    end

    always @(posedge clk) if (popA) arp <= arp + 8'd1;

    task automatic push(input logic [15:0] w);
        amem[awp] = w;
        awp = awp + 8'd1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_txv !== 1'b0) begin bad++; $display("FAIL rst_txValid got=%b exp=0", a_txv); end
        total++; if (a_rd !== 1'b0) begin bad++; $display("FAIL rst_dataRead got=%b exp=0", a_rd); end
        total++; if (a_txd !== 8'h00) begin bad++; $display("FAIL rst_txData got=%h exp=00", a_txd); end
        total++; if (a_seq !== 8'h00) begin bad++; $display("FAIL rst_seqNum got=%h exp=00", a_seq); end
        total++; if (a_done !== 1'b0 || a_abort !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b exp=00", a_done, a_abort); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame;
        logic [7:0] exp [12];
        int c0, d0, r0;
        exp = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        c0 = acapN; d0 = doneCnt; r0 = rdCnt;
        push(16'h0102); push(16'h0304); push(16'h0506); push(16'h0708);
        a_rdy = 1'b1; a_en = 1'b1;
        for (int i = 0; i < 300 && doneCnt == d0; i++) @(negedge clk);
        a_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (doneCnt - d0 !== 1) begin bad++; $display("FAIL t1_done got=%0d exp=1", doneCnt - d0); end
        total++; if (acapN - c0 !== 12) begin bad++; $display("FAIL t1_count got=%0d exp=12", acapN - c0); end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (acap[c0 + k] !== exp[k]) begin bad++; $display("FAIL t1_byte%0d got=%h exp=%h", k, acap[c0 + k], exp[k]); end
        end
        total++; if (a_seq !== 8'h01) begin bad++; $display("FAIL t1_seq got=%h exp=01", a_seq); end
        total++; if (rdCnt - r0 !== 4) begin bad++; $display("FAIL t1_reads got=%0d exp=4", rdCnt - r0); end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [12];
        int c0, d0;
        exp = '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h25};
        c0 = acapN; d0 = doneCnt;
        push(16'h0102); push(16'h0304); push(16'h0506); push(16'h0708);
        a_en = 1'b1;
        for (int i = 0; i < 600 && doneCnt == d0; i++) begin
            @(posedge clk); #1;
            a_rdy = 1'($urandom_range(0, 1));
            if (a_txv) a_en = 1'b0;
        end
        a_rdy = 1'b1; a_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (doneCnt - d0 !== 1) begin bad++; $display("FAIL t2_done got=%0d exp=1", doneCnt - d0); end
        total++; if (acapN - c0 !== 12) begin bad++; $display("FAIL t2_count got=%0d exp=12", acapN - c0); end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (acap[c0 + k] !== exp[k]) begin bad++; $display("FAIL t2_byte%0d got=%h exp=%h", k, acap[c0 + k], exp[k]); end
        end
        total++; if (stabErr !== 0) begin bad++; $display("FAIL t2_stable got=%0d exp=0", stabErr); end
        total++; if (popEmpty !== 0) begin bad++; $display("FAIL t2_pop_empty got=%0d exp=0", popEmpty); end
    endtask

    task automatic test_underrun;
        logic [7:0] exp [7];
        int c0, d0, a0;
        exp = '{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
        c0 = acapN; d0 = doneCnt; a0 = abortCnt;
        push(16'h0102); push(16'h0304);
        a_en = 1'b1;
        for (int i = 0; i < 300 && abortCnt == a0; i++) @(negedge clk);
        a_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (abortCnt - a0 !== 1) begin bad++; $display("FAIL t3_abort got=%0d exp=1", abortCnt - a0); end
        total++; if (acapN - c0 !== 7) begin bad++; $display("FAIL t3_count got=%0d exp=7", acapN - c0); end
        for (int k = 0; k < 7; k++) begin
            total++;
            if (acap[c0 + k] !== exp[k]) begin bad++; $display("FAIL t3_byte%0d got=%h exp=%h", k, acap[c0 + k], exp[k]); end
        end
        // Acceptance sampled one half-cycle before the edge that enters LOAD, then 16 LOAD cycles
        total++; if (abortCyc - lastAcc !== 17) begin bad++; $display("FAIL t3_timing got=%0d exp=17", abortCyc - lastAcc); end
        total++; if (doneCnt - d0 !== 0) begin bad++; $display("FAIL t3_no_done got=%0d exp=0", doneCnt - d0); end
        total++; if (a_seq !== 8'h02) begin bad++; $display("FAIL t3_seq got=%h exp=02", a_seq); end
        total++; if (a_txv !== 1'b0) begin bad++; $display("FAIL t3_txValid got=%b exp=0", a_txv); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] exp [12];
        int c0, d0, hit;
        exp = '{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h54};
        push(16'h0102); push(16'h0304); push(16'h0506); push(16'h0708);
        a_en = 1'b1;
        hit = 0;
        for (int i = 0; i < 300 && hit == 0; i++) begin
            @(negedge clk);
            if (a_txv && a_txd == 8'h04) hit = 1;
        end
        a_en = 1'b0;
        total++; if (hit !== 1) begin bad++; $display("FAIL t5_reach_lo got=%0d exp=1", hit); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (a_txv !== 1'b0) begin bad++; $display("FAIL t5_txValid got=%b exp=0", a_txv); end
        total++; if (a_rd !== 1'b0) begin bad++; $display("FAIL t5_dataRead got=%b exp=0", a_rd); end
        total++; if (a_seq !== 8'h00) begin bad++; $display("FAIL t5_seq got=%h exp=00", a_seq); end
        rst = 1'b1;
        awp = arp;
        @(posedge clk); #1;
        c0 = acapN; d0 = doneCnt;
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        a_en = 1'b1;
        for (int i = 0; i < 300 && doneCnt == d0; i++) @(negedge clk);
        a_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (acapN - c0 !== 12) begin bad++; $display("FAIL t5_count got=%0d exp=12", acapN - c0); end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (acap[c0 + k] !== exp[k]) begin bad++; $display("FAIL t5_byte%0d got=%h exp=%h", k, acap[c0 + k], exp[k]); end
        end
        total++; if (a_seq !== 8'h01) begin bad++; $display("FAIL t5_seq_after got=%h exp=01", a_seq); end
    endtask

    task automatic test_enable_gate;
        logic [7:0] exp [12];
        int c0, d0, v0, r0;
        exp = '{8'hA5, 8'h5A, 8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h6D};
        a_en = 1'b0;
        push(16'h0A0B); push(16'h0C0D); push(16'h0E0F); push(16'h1011);
        v0 = txvCnt; r0 = rdCnt;
        repeat (100) @(posedge clk);
        #1;
        total++; if (txvCnt - v0 !== 0) begin bad++; $display("FAIL t6_no_txValid got=%0d exp=0", txvCnt - v0); end
        total++; if (rdCnt - r0 !== 0) begin bad++; $display("FAIL t6_no_read got=%0d exp=0", rdCnt - r0); end
        c0 = acapN; d0 = doneCnt;
        a_en = 1'b1;
        @(posedge clk); #1;
        total++; if (a_txv !== 1'b1 || a_txd !== 8'hA5) begin bad++; $display("FAIL t6_hdr0 got=%b/%h exp=1/a5", a_txv, a_txd); end
        a_en = 1'b0;
        for (int i = 0; i < 300 && doneCnt == d0; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        total++; if (acapN - c0 !== 12) begin bad++; $display("FAIL t6_count got=%0d exp=12", acapN - c0); end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (acap[c0 + k] !== exp[k]) begin bad++; $display("FAIL t6_byte%0d got=%h exp=%h", k, acap[c0 + k], exp[k]); end
        end
        total++; if (a_seq !== 8'h02) begin bad++; $display("FAIL t6_seq got=%h exp=02", a_seq); end
    endtask

    task automatic test_seq_wrap;
        int n, c0;
        logic [7:0] s;
        c0 = bcapN;
        n = 0;
        b_rdy = 1'b1; b_en = 1'b1;
        for (int i = 0; i < 5000 && n < 257; i++) begin
            @(negedge clk);
            if (b_done) n++;
        end
        b_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (n !== 257) begin bad++; $display("FAIL t4_frames got=%0d exp=257", n); end
        total++; if (bcapN - c0 !== 1542) begin bad++; $display("FAIL t4_count got=%0d exp=1542", bcapN - c0); end
        for (int k = 0; k < 257; k++) begin
            s = 8'(k);
            total++;
            if (bcap[c0 + k*6 + 2] !== s) begin bad++; $display("FAIL t4_seq%0d got=%h exp=%h", k, bcap[c0 + k*6 + 2], s); end
            total++;
            if (bcap[c0 + k*6 + 5] !== s) begin bad++; $display("FAIL t4_csum%0d got=%h exp=%h", k, bcap[c0 + k*6 + 5], s); end
        end
        total++; if (b_seq !== 8'h01) begin bad++; $display("FAIL t4_seq_after got=%h exp=01", b_seq); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_underrun();
        test_reset_midframe();
        test_enable_gate();
        test_seq_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
